// File: rtl/bksave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bksave_ctrl
// Purpose  : Backup-RAM save/load/format sequencer between hps_io sd_* and BRAM port B.
// Revision : 1.0
// ============================================================================
module bksave_ctrl #(
    parameter int SECTOR_BITS = 4,
    parameter int SLOT_BITS   = 2,
    parameter int DEF_WORDS   = 4,
    parameter logic [16*DEF_WORDS-1:0] DEF_VAL = {16'h5548, 16'h4D42, 16'h8800, 16'h8010}
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 image_present,
    input  logic                 mount_done,
    input  logic                 osd_status,
    input  logic                 autosave,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic                 format_req,
    input  logic                 bram_write,
    input  logic                 sd_ack,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [3:0]           def_addr,
    output logic [15:0]          def_data,
    output logic                 def_we,
    output logic                 busy,
    output logic                 loading,
    output logic                 pending,
    output logic                 led
);

    localparam int LBA_PAD = 32 - SLOT_BITS - SECTOR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_armed;
    logic                   r_load_prev;
    logic                   r_save_prev;
    logic                   r_fmt_prev;
    logic                   r_ack;
    logic                   r_ack_prev;

    logic [SLOT_BITS-1:0]   r_slot;
    logic [SECTOR_BITS-1:0] r_idx;
    logic [3:0]             r_fidx;
    logic                   r_sd_rd;
    logic                   r_sd_wr;
    logic                   r_busy;
    logic                   r_loading;
    logic                   r_pending;

    logic                   w_save_trig;
    logic                   w_load_edge;
    logic                   w_save_edge;
    logic                   w_fmt_edge;
    logic                   w_ack_rise;
    logic                   w_ack_fall;
    logic                   w_start_load;
    logic                   w_start_xfer;
    logic                   w_idx_last;
    logic                   w_fmt_last;
    logic                   w_pend_set;
    logic                   w_def_we;
    logic [15:0]            w_def_word;

    // r_armed masks edges on the first cycle after reset so a request level
    // that is still high when reset releases is absorbed rather than acted on.
    assign w_save_trig  = save_req | (r_pending & osd_status & autosave);
    assign w_load_edge  = r_armed & load_req    & ~r_load_prev;
    assign w_save_edge  = r_armed & w_save_trig & ~r_save_prev;
    assign w_fmt_edge   = r_armed & format_req  & ~r_fmt_prev;
    assign w_ack_rise   = r_ack  & ~r_ack_prev;
    assign w_ack_fall   = ~r_ack & r_ack_prev;

    assign w_start_load = enable & ((mount_done & image_present) | w_load_edge);
    assign w_start_xfer = w_start_load | (enable & w_save_edge);
    assign w_idx_last   = &r_idx;
    assign w_fmt_last   = (r_fidx == 4'(DEF_WORDS - 1));
    assign w_pend_set   = enable & ~osd_status & bram_write;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_def_we = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_xfer) begin
                    w_next = ST_XFER;
                end else if (w_fmt_edge) begin
                    w_next = ST_FORMAT;
                end
            end
            ST_XFER: begin
                if (w_ack_fall && w_idx_last) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FORMAT: begin
                w_def_we = 1'b1;
                if (w_fmt_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_def_word = 16'd0;
        for (int i = 0; i < DEF_WORDS; i++) begin
            if (r_fidx == i[3:0]) begin
                w_def_word = DEF_VAL[16*(DEF_WORDS-1-i) +: 16];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_load_prev <= 1'b0;
            r_save_prev <= 1'b0;
            r_fmt_prev  <= 1'b0;
            r_ack       <= 1'b0;
            r_ack_prev  <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_load_prev <= load_req;
            r_save_prev <= w_save_trig;
            r_fmt_prev  <= format_req;
            r_ack       <= sd_ack;
            r_ack_prev  <= r_ack;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_slot    <= '0;
            r_idx     <= '0;
            r_fidx    <= 4'd0;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fidx <= 4'd0;
                    if (w_start_xfer) begin
                        r_slot    <= slot;
                        r_idx     <= '0;
                        r_loading <= w_start_load;
                        r_sd_rd   <= w_start_load;
                        r_sd_wr   <= ~w_start_load;
                        r_busy    <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                    end else if (w_ack_fall) begin
                        if (w_idx_last) begin
                            r_busy    <= 1'b0;
                            r_loading <= 1'b0;
                        end else begin
                            // Index is SECTOR_BITS wide, so the slot field never changes.
                            r_idx   <= r_idx + 1'b1;
                            r_sd_rd <= r_loading;
                            r_sd_wr <= ~r_loading;
                        end
                    end
                end
                ST_FORMAT: begin
                    if (!w_fmt_last) begin
                        r_fidx <= r_fidx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pend_set) begin
                        r_pending <= 1'b1;
                    end else if (w_start_xfer) begin
                        r_pending <= 1'b0;
                    end
                end
                ST_FORMAT: begin
                    if (w_pend_set || (w_fmt_last && enable)) begin
                        r_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sd_lba   = {{LBA_PAD{1'b0}}, r_slot, r_idx};
    assign sd_rd    = r_sd_rd;
    assign sd_wr    = r_sd_wr;
    assign def_we   = w_def_we;
    assign def_addr = w_def_we ? r_fidx : 4'd0;
    assign def_data = w_def_we ? w_def_word : 16'd0;
    assign busy     = r_busy;
    assign loading  = r_loading;
    assign pending  = r_pending;
    assign led      = r_busy | (autosave & r_pending);

endmodule
`default_nettype wire
